// File: rtl/imem_arbiter.sv
// Two-port arbiter sharing one instruction memory between the fetch unit and a program loader.
// Optional boot hold (macro IMEM_BOOT_HOLD_EN) blocks fetch until the loader signals l_done.
module imem_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [31:0]       l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    input  logic              l_done,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fetch_hold,
    output logic [15:0]       conflict_cnt
);

    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

`ifdef IMEM_BOOT_HOLD_EN
    localparam state_t RESET_STATE = BOOT;
`else
    localparam state_t RESET_STATE = RUN;
`endif

    state_t      state_q, state_d;
    logic        last_l_q, last_l_d;
    logic        f_rv_q, f_rv_d;
    logic        l_rv_q, l_rv_d;
    logic [15:0] cnt_q, cnt_d;
    logic        f_cand, l_cand, contend;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RESET_STATE;
            last_l_q <= 1'b1;
            f_rv_q   <= 1'b0;
            l_rv_q   <= 1'b0;
            cnt_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            last_l_q <= last_l_d;
            f_rv_q   <= f_rv_d;
            l_rv_q   <= l_rv_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef IMEM_BOOT_HOLD_EN
        if (state_q == BOOT && l_done) begin
            state_d = RUN;
        end
`else
        state_d = RUN;
`endif
    end

    // Grants are gated by rst so nothing reaches the memory while in reset.
    always_comb begin
        f_cand  = f_req & (state_q == RUN) & ~rst;
        l_cand  = l_req & ~rst;
        contend = f_cand & l_cand;
        f_gnt   = f_cand & (~l_cand | last_l_q);
        l_gnt   = l_cand & (~f_cand | ~last_l_q);

        last_l_d = last_l_q;
        if (f_gnt || l_gnt) begin
            last_l_d = l_gnt;
        end
        f_rv_d = f_gnt;
        l_rv_d = l_gnt & ~l_we;

        cnt_d = cnt_q;
        if (contend && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    assign mem_en    = f_gnt | l_gnt;
    assign mem_we    = l_gnt & l_we;
    assign mem_addr  = l_gnt ? l_addr[ADDR_W+1:2] : f_addr[ADDR_W+1:2];
    assign mem_wdata = l_wdata;

    // Masking with rst cancels a response whose read was granted just before reset.
    assign f_rvalid = f_rv_q & ~rst;
    assign l_rvalid = l_rv_q & ~rst;
    assign f_rdata  = f_rvalid ? mem_rdata : '0;
    assign l_rdata  = l_rvalid ? mem_rdata : '0;

    assign conflict_cnt = rst ? 16'd0 : cnt_q;

`ifdef IMEM_BOOT_HOLD_EN
    assign fetch_hold = (state_q == BOOT);
`else
    assign fetch_hold = 1'b0;
`endif

    // Byte-offset and out-of-range address bits are deliberately dropped.
    logic unused_ok;
    assign unused_ok = ^{f_addr[31:ADDR_W+2], f_addr[1:0],
                         l_addr[31:ADDR_W+2], l_addr[1:0], l_done};

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: directed vectors, read responses checked by a monitor.
module tb_imem_arbiter;

`ifdef IMEM_BOOT_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = '0;
    logic        f_gnt, f_rvalid;
    logic [31:0] f_rdata;
    logic        l_req = 1'b0;
    logic        l_we = 1'b0;
    logic [31:0] l_addr = '0;
    logic [31:0] l_wdata = '0;
    logic        l_done = 1'b0;
    logic        l_gnt, l_rvalid;
    logic [31:0] l_rdata;
    logic        mem_en, mem_we;
    logic [12:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        fetch_hold;
    logic [15:0] conflict_cnt;

    imem_arbiter #(.ADDR_W(13), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_done(l_done),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .fetch_hold(fetch_hold), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural memory with one-cycle read latency.
    logic [31:0] mem [0:8191];
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic        is_f;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic is_f, input logic [31:0] data);
        exp_t e;
        e.is_f = is_f;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rvalid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (f_rvalid || l_rvalid) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rvalid_unexpected: got f_rvalid=%0b l_rvalid=%0b expected none",
                         f_rvalid, l_rvalid);
            end else begin
                mon_e = exp_q.pop_front();
                if (f_rvalid !== mon_e.is_f || l_rvalid !== !mon_e.is_f ||
                    (mon_e.is_f ? f_rdata : l_rdata) !== mon_e.data) begin
                    miscompares++;
                    $display("FAIL rdata: got f_rvalid=%0b l_rvalid=%0b data=%h expected %s data=%h",
                             f_rvalid, l_rvalid, mon_e.is_f ? f_rdata : l_rdata,
                             mon_e.is_f ? "fetch" : "loader", mon_e.data);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fgnts;
        // Reset with both requests asserted: everything quiet.
        f_req = 1'b1;
        l_req = 1'b1;
        step();
        step();
        chk("rst_f_gnt", f_gnt, 0);
        chk("rst_l_gnt", l_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_rvalid", {f_rvalid, l_rvalid}, 0);
        chk("rst_rdata", f_rdata | l_rdata, 0);
        chk("rst_cnt", conflict_cnt, 0);

        step();
        rst = 1'b0;
        f_req = HOLD;
        f_addr = 32'h13;
        l_req = 1'b0;
        #1;
        chk("hold_after_rst", fetch_hold, HOLD);
        if (HOLD) begin
            for (int i = 0; i < 100; i++) begin
                step();
                chk("boot_f_gnt", f_gnt, 0);
                chk("boot_hold", fetch_hold, 1);
            end
        end

        // Loader write coincident with l_done.
        step();
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'h10; l_wdata = 32'hDEADBEEF; l_done = 1'b1;
        #1;
        chk("load_l_gnt", l_gnt, 1);
        chk("load_f_gnt", f_gnt, 0);
        chk("load_we", mem_we, 1);
        chk("load_addr", mem_addr, 4);

        step();
        l_req = 1'b0; l_done = 1'b0; f_req = 1'b1; f_addr = 32'h13;
        #1;
        chk("fetch_gnt", f_gnt, 1);
        chk("fetch_en", mem_en, 1);
        chk("fetch_we", mem_we, 0);
        chk("fetch_addr", mem_addr, 4);
        chk("run_hold", fetch_hold, 0);
        if (f_gnt) push(1'b1, 32'hDEADBEEF);

        step();
        f_req = 1'b0; l_req = 1'b1; l_we = 1'b0; l_addr = 32'h10;
        #1;
        chk("lread_gnt", l_gnt, 1);
        if (l_gnt) push(1'b0, 32'hDEADBEEF);

        // Address wrap: 0x8004 and 0xFFFF8005 both map to word 1.
        step();
        l_we = 1'b1; l_addr = 32'h0000_8004; l_wdata = 32'h12345678;
        #1;
        chk("wrap_waddr", mem_addr, 1);
        chk("wrap_we", mem_we, 1);

        step();
        l_req = 1'b0; f_req = 1'b1; f_addr = 32'hFFFF_8005;
        #1;
        chk("wrap_raddr", mem_addr, 1);
        if (f_gnt) push(1'b1, 32'h12345678);

        step();
        f_req = 1'b0; l_req = 1'b1; l_we = 1'b0; l_addr = 32'h0000_8004;
        #1;
        chk("wrap_lgnt", l_gnt, 1);
        if (l_gnt) push(1'b0, 32'h12345678);

        // Contention after a loader grant: F,L,F,L,F,L.
        for (int k = 0; k < 6; k++) begin
            step();
            f_req = 1'b1; f_addr = 32'h4; l_req = 1'b1; l_we = 1'b0; l_addr = 32'h10;
            #1;
            chk("rr_f_gnt", f_gnt, (k % 2 == 0));
            chk("rr_l_gnt", l_gnt, (k % 2 != 0));
            chk("rr_cnt", conflict_cnt, k);
            if (f_gnt) push(1'b1, 32'h12345678);
            if (l_gnt) push(1'b0, 32'hDEADBEEF);
        end
        step();
        f_req = 1'b0; l_req = 1'b0;
        #1;
        chk("rr_cnt_final", conflict_cnt, 6);

        // Reset the cycle after a fetch read grant.
        step();
        f_req = 1'b1; f_addr = 32'h4;
        #1;
        chk("midrst_gnt", f_gnt, 1);
        step();
        f_req = 1'b0; rst = 1'b1;
        #1;
        chk("midrst_rvalid", f_rvalid, 0);
        chk("midrst_cnt", conflict_cnt, 0);
        step();
        rst = 1'b0;
        #1;
        chk("postrst_rvalid", f_rvalid, 0);
        chk("postrst_cnt", conflict_cnt, 0);
        chk("postrst_hold", fetch_hold, HOLD);

        step();
        l_done = 1'b1;
        #1;
        step();
        l_done = 1'b0;
        #1;
        chk("rerun_hold", fetch_hold, 0);

        // Saturation: fetch reads word 1 against loader writes to word 8.
        fgnts = 0;
        for (int i = 0; i < 70000; i++) begin
            step();
            f_req = 1'b1; f_addr = 32'h4;
            l_req = 1'b1; l_we = 1'b1; l_addr = 32'h20; l_wdata = 32'hA5A5A5A5;
            #1;
            if (i == 0) chk("sat_fetch_first", f_gnt, 1);
            if (i == 65534) chk("sat_cnt_fffe", conflict_cnt, 16'hFFFE);
            if (i == 65535) chk("sat_cnt_ffff", conflict_cnt, 16'hFFFF);
            if (f_gnt) begin
                fgnts++;
                push(1'b1, 32'h12345678);
            end
        end
        step();
        f_req = 1'b0; l_req = 1'b0;
        #1;
        chk("sat_cnt_final", conflict_cnt, 16'hFFFF);
        chk("sat_fetch_grants", fgnts, 35000);

        step();
        step();
        step();
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
